// File: rtl/wisc_pkg.sv
// Shared types and constants for the memory stage of the 16-bit pipeline.
package wisc_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [DATA_W-1:0] BUS_ERR_DATA = 16'hFFFF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // MEM/WB payload consumed by the write-back unit.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] reg_rd;
    logic [DATA_W-1:0] mem_read_data;
    logic [DATA_W-1:0] alu_result;
  } mem_wb_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus.
//   master: drives dmem_req/we/addr/wdata, receives dmem_rdata/ack
//   slave : the memory side
interface mem_access_stage_if;
  import wisc_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register.
//   load   : capture d
//   bubble : clear valid/reg_write, hold the remaining fields (wins over load)
//   q      : registered bundle to write-back
module mem_wb_reg
  import wisc_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load,
  input  logic    bubble,
  input  mem_wb_t d,
  output mem_wb_t q
);

  mem_wb_t q_d, q_q;

  // Next-value select.
  always_comb begin
    q_d = q_q;
    if (bubble) begin
      q_d.valid     = 1'b0;
      q_d.reg_write = 1'b0;
    end else if (load) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: runs loads/stores over a multi-cycle req/ack bus, stalls
// upstream while an access is outstanding, and registers the MEM/WB bundle.
//   ex_*      : EX/MEM bundle (held stable by upstream while stall_mem=1)
//   flush     : kill the instruction in this stage
//   stall_mem : combinational hold request to upstream
//   dmem      : data-memory bus (master side)
//   wb_*      : registered MEM/WB bundle
//   bus_err   : one-cycle pulse when an access times out
module mem_access_stage
  import wisc_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic                ex_mem_to_reg,
  input  logic                ex_reg_write,
  input  logic [REG_AW-1:0]   ex_reg_rd,
  input  logic [DATA_W-1:0]   ex_alu_result,
  input  logic [DATA_W-1:0]   ex_store_data,
  input  logic                flush,
  output logic                stall_mem,
  mem_access_stage_if.master  dmem,
  output logic                wb_valid,
  output logic                wb_reg_write,
  output logic                wb_mem_to_reg,
  output logic [REG_AW-1:0]   wb_reg_rd,
  output logic [DATA_W-1:0]   wb_mem_read_data,
  output logic [DATA_W-1:0]   wb_alu_result,
  output logic                bus_err
);

  mem_state_t        state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              killed_d, killed_q;
  logic              req_d, req_q;
  logic              we_d, we_q;
  logic [DATA_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic              bus_err_d, bus_err_q;

  logic    memop;
  logic    timeout_hit;
  logic    wb_load, wb_bubble;
  mem_wb_t wb_d, wb_q;

  assign memop = ex_valid & (ex_mem_read | ex_mem_write);

  // Ack in the last allowed cycle still counts as a normal completion.
  assign timeout_hit = (TIMEOUT != 0) && (state_q == ACCESS) && !dmem.dmem_ack &&
                       (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state, bus request and MEM/WB control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    killed_d  = killed_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bus_err_d = 1'b0;
    stall_mem = 1'b0;
    wb_load   = 1'b0;
    wb_bubble = 1'b0;

    wb_d.valid         = ex_valid & ~flush;
    wb_d.reg_write     = ex_reg_write & ex_valid & ~flush;
    wb_d.mem_to_reg    = ex_mem_to_reg;
    wb_d.reg_rd        = ex_reg_rd;
    wb_d.mem_read_data = '0;
    wb_d.alu_result    = ex_alu_result;

    unique case (state_q)
      IDLE: begin
        if (memop && !flush) begin
          stall_mem = 1'b1;
          wb_bubble = 1'b1;
          state_d   = ACCESS;
          cnt_d     = '0;
          killed_d  = 1'b0;
          req_d     = 1'b1;
          we_d      = ex_mem_write;   // read+write together behaves as a store
          addr_d    = ex_alu_result;
          wdata_d   = ex_store_data;
        end else begin
          wb_load = 1'b1;
        end
      end

      ACCESS: begin
        stall_mem = ~(dmem.dmem_ack | timeout_hit);
        if (dmem.dmem_ack || timeout_hit) begin
          state_d  = IDLE;
          cnt_d    = '0;
          killed_d = 1'b0;
          req_d    = 1'b0;
          // A flush arriving on the completing cycle kills it as well.
          if (killed_q || flush) begin
            wb_bubble = 1'b1;
          end else begin
            wb_load        = 1'b1;
            wb_d.valid     = 1'b1;
            wb_d.reg_write = ex_reg_write;
            if (timeout_hit) begin
              wb_d.mem_read_data = BUS_ERR_DATA;
              wb_d.reg_write     = 1'b0;
            end else if (!we_q) begin
              wb_d.mem_read_data = dmem.dmem_rdata;
            end
          end
          bus_err_d = timeout_hit;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          killed_d = killed_q | flush;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      killed_q  <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      killed_q  <= killed_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bus_err_q <= bus_err_d;
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (wb_load),
    .bubble (wb_bubble),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  assign wb_valid         = wb_q.valid;
  assign wb_reg_write     = wb_q.reg_write;
  assign wb_mem_to_reg    = wb_q.mem_to_reg;
  assign wb_reg_rd        = wb_q.reg_rd;
  assign wb_mem_read_data = wb_q.mem_read_data;
  assign wb_alu_result    = wb_q.alu_result;
  assign bus_err          = bus_err_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 16-bit five-stage pipeline, directly upstream of the write-back unit.
- Accepts the EX/MEM bundle and performs loads and stores over a req/ack data-memory bus that may take multiple cycles.
- Stalls upstream while an access is outstanding.
- Registers the MEM/WB bundle (read data, ALU result, mem_to_reg, destination register, reg_write) that write-back consumes.

Parameters:
- DATA_W, 16, data and address width.
- REG_AW, 4, register specifier width (16 registers).
- TIMEOUT, 15, cycles in ACCESS without ack before bus error; 0 disables timeout; max 255.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX/MEM bundle holds a live instruction.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_mem_to_reg  in  1  write-back selects memory data.
- ex_reg_write  in  1  instruction writes a register.
- ex_reg_rd  in  REG_AW  destination register.
- ex_alu_result  in  DATA_W  ALU result / memory word address.
- ex_store_data  in  DATA_W  store data.
- flush  in  1  kill the instruction currently in this stage.
- stall_mem  out  1  upstream must hold the EX/MEM bundle (combinational).
- dmem_req  out  1  memory request.
- dmem_we  out  1  1=write, 0=read.
- dmem_addr  out  DATA_W  word address.
- dmem_wdata  out  DATA_W  write data.
- dmem_rdata  in  DATA_W  read data, valid with ack.
- dmem_ack  in  1  access complete.
- wb_valid  out  1  MEM/WB holds a live instruction.
- wb_reg_write  out  1  to register file write enable.
- wb_mem_to_reg  out  1  write-back mux select.
- wb_reg_rd  out  REG_AW  destination register to write-back.
- wb_mem_read_data  out  DATA_W  captured load data.
- wb_alu_result  out  DATA_W  ALU result passthrough.
- bus_err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; timeout counter 0; killed flag 0.
  - All registered outputs 0: wb_*, dmem_req, dmem_we, dmem_addr, dmem_wdata, bus_err.
  - Reset mid-access drops dmem_req immediately; the memory side must tolerate abandonment.
- memop = ex_valid & (ex_mem_read | ex_mem_write). Both read and write set: treated as store.
- IDLE, no memop or flush=1:
  - MEM/WB loads the bundle next edge: 1-cycle latency.
  - wb_valid = ex_valid & ~flush; wb_reg_write = ex_reg_write & wb_valid; wb_mem_read_data = 0.
  - stall_mem = 0.
- IDLE, memop and flush=0:
  - stall_mem = 1.
  - Capture addr, we and wdata into request registers; next state ACCESS.
  - MEM/WB loads a bubble: wb_valid=0, wb_reg_write=0, other wb fields hold.
- ACCESS:
  - dmem_req=1 with stable addr, we and wdata until ack or timeout.
  - stall_mem = ~(dmem_ack | timeout_hit).
  - Counter increments each non-ack cycle.
  - dmem_ack=1: MEM/WB loads the bundle with wb_mem_read_data = dmem_rdata (stores: 0); dmem_req falls next edge; return to IDLE; counter cleared.
  - Minimum memop latency is 2 cycles: capture cycle plus ACCESS-with-ack cycle.
- Timeout (TIMEOUT>0, counter==TIMEOUT-1 with no ack):
  - Treated as completion with wb_mem_read_data = 16'hFFFF and wb_reg_write forced 0.
  - bus_err=1 for one cycle; return to IDLE.
- flush during ACCESS:
  - The request is not cancelled; the req/ack handshake completes.
  - Set killed; on completion MEM/WB loads a bubble instead; killed cleared.
- dmem_ack while IDLE: ignored.
- Back-to-back memops: after the completing edge, IDLE sees the next bundle and immediately re-captures, so there is one idle bus cycle between requests.
- Upstream contract: ex_* fields are stable whenever stall_mem=1.

Decomposition:
- wisc_pkg:
  - mem_state_t enum {IDLE, ACCESS}.
  - DATA_W and REG_AW constants.
  - BUS_ERR_DATA = 16'hFFFF.
  - Packed struct mem_wb_t carrying valid, reg_write, mem_to_reg, reg_rd, mem_read_data, alu_result.
- One sub-module, mem_wb_reg: the MEM/WB pipeline register with load/bubble control and async reset.
- The FSM, counter and bus drive stay in mem_access_stage.

Test Plan:
- ALU op (ex_reg_rd=3, alu_result=16'h00A5, mem_to_reg=0) -> next edge wb_valid=1, wb_reg_rd=3, wb_alu_result=16'h00A5, stall_mem=0.
- Load addr 16'h0040, ack 3 cycles after req with rdata=16'hBEEF -> stall_mem high 4 cycles; wb_mem_read_data=16'hBEEF, wb_mem_to_reg=1; bubbles before.
- Store addr 16'h0010, data 16'h1234, ack in first ACCESS cycle -> dmem_we=1, addr/wdata stable; 2-cycle latency; wb_reg_write=0.
- TIMEOUT=4, load never acked -> req high 4 cycles; bus_err single pulse; wb_mem_read_data=16'hFFFF; wb_reg_write=0; IDLE after.
- flush asserted in the 2nd ACCESS cycle, ack later -> req held until ack; MEM/WB receives bubble (wb_valid=0).
- rst_n low during ACCESS -> dmem_req and all wb_* are 0 immediately; after release, a new load completes normally.
